// File: rtl/dm_abstract_ctrl.sv
// -----------------------------------------------------------------------------
// dm_abstract_ctrl
//
// Abstract command sequencer for the RISC-V debug module. A command word
// written by the debugger (or replayed through autoexec) is checked against
// the supported subset: Access Register only, no post-increment, legal
// aarsize, and a CSR or GPR regno. An accepted command has its control fields
// latched for the program-buffer/ROM generator. It is then handed to the
// selected halted hart with a go/going handshake, and the sequencer waits for
// the hart to report done or exception. The block owns abstractcs.busy and
// the sticky abstractcs.cmderr field.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   dmactive_i         dmcontrol.dmactive; low clears the block synchronously
//   cmd_valid_i        pulse: command register written with cmd_i
//   cmd_i[31:0]        command word (cmdtype[31:24], control[23:0])
//   autoexec_i         pulse: re-run the stored command
//   data_access_i      pulse: any data/progbuf access
//   cmderr_clr_i[2:0]  write-1-to-clear mask for cmderr
//   hart_halted_i      selected hart is halted
//   hart_going_i       hart acknowledges go
//   hart_done_i        pulse: hart finished the command
//   hart_exception_i   pulse: hart took an exception during the command
//   go_o               request the hart to execute the command
//   busy_o             abstractcs.busy
//   cmderr_o[2:0]      abstractcs.cmderr
//   transfer_o, write_o, postexec_o, aarsize_o[2:0], regno_o[15:0]
//                      control fields of the last accepted command
// -----------------------------------------------------------------------------
module dm_abstract_ctrl #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        autoexec_i,
    input  logic        data_access_i,
    input  logic [2:0]  cmderr_clr_i,
    input  logic        hart_halted_i,
    input  logic        hart_going_i,
    input  logic        hart_done_i,
    input  logic        hart_exception_i,
    output logic        go_o,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic        transfer_o,
    output logic        write_o,
    output logic        postexec_o,
    output logic [2:0]  aarsize_o,
    output logic [15:0] regno_o
);

    localparam int unsigned     CntW    = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    localparam logic [2:0] ErrNone         = 3'd0;
    localparam logic [2:0] ErrBusy         = 3'd1;
    localparam logic [2:0] ErrNotSupported = 3'd2;
    localparam logic [2:0] ErrException    = 3'd3;
    localparam logic [2:0] ErrHaltResume   = 3'd4;
    localparam logic [2:0] ErrOther        = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        EXEC = 2'd2
    } state_e;

    typedef struct packed {
        logic        transfer;
        logic        write;
        logic        postexec;
        logic [2:0]  aarsize;
        logic [15:0] regno;
    } fields_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      cmderr_q, cmderr_d;
    logic [31:0]     cmd_q, cmd_d;
    fields_t         fields_q, fields_d;

    logic [31:0] eval_cmd;
    logic [2:0]  cmderr_cleared;
    logic        start;
    logic        access;
    logic        size_ok;
    logic        regno_ok;
    logic        unsupported;
    logic        unused_reserved;

    // A fresh write is evaluated directly; autoexec replays the stored word.
    assign eval_cmd       = cmd_valid_i ? cmd_i : cmd_q;
    assign cmderr_cleared = cmderr_q & ~cmderr_clr_i;
    assign start          = cmd_valid_i | autoexec_i;
    assign access         = start | data_access_i;

    // 64-bit accesses are only legal on a 64-bit hart.
    assign size_ok  = (eval_cmd[22:20] == 3'd2) ||
                      ((BusWidth == 64) && (eval_cmd[22:20] == 3'd3));
    // CSRs 0x0000-0x0FFF and GPRs 0x1000-0x101F form one contiguous range.
    assign regno_ok = (eval_cmd[15:0] <= 16'h101F);

    assign unsupported = (eval_cmd[31:24] != 8'd0) || eval_cmd[19] ||
                         (eval_cmd[17] && (!size_ok || !regno_ok));

    // Bit 23 is reserved in the Access Register layout and carries no meaning.
    assign unused_reserved = eval_cmd[23];

    // NOTE: every _d signal takes its held value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmderr_d = cmderr_cleared;
        cmd_d    = cmd_q;
        fields_d = fields_q;

        // Busy error is raised before any state event so that a timeout or
        // exception in the same cycle still reports the hart-side cause.
        if (state_q != IDLE && access && cmderr_cleared == ErrNone) begin
            cmderr_d = ErrBusy;
        end

        case (state_q)
            IDLE: begin
                if (start && cmderr_cleared == ErrNone) begin
                    if (cmd_valid_i) begin
                        cmd_d = cmd_i;
                    end
                    if (unsupported) begin
                        cmderr_d = ErrNotSupported;
                    end else if (!hart_halted_i) begin
                        cmderr_d = ErrHaltResume;
                    end else begin
                        fields_d = '{transfer: eval_cmd[17],
                                     write:    eval_cmd[16],
                                     postexec: eval_cmd[18],
                                     aarsize:  eval_cmd[22:20],
                                     regno:    eval_cmd[15:0]};
                        // Neither transfer nor postexec: nothing for the hart.
                        if (eval_cmd[17] || eval_cmd[18]) begin
                            state_d = GO;
                            cnt_d   = '0;
                        end
                    end
                end
            end

            GO: begin
                if (hart_going_i) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    cmderr_d = ErrOther;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            EXEC: begin
                // An exception reported alongside done still marks a failure.
                if (hart_exception_i) begin
                    cmderr_d = ErrException;
                    state_d  = IDLE;
                end else if (hart_done_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Debug module inactive: everything returns to its cleared state.
        if (!dmactive_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            cmderr_d = ErrNone;
            cmd_d    = '0;
            fields_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmderr_q <= ErrNone;
            cmd_q    <= '0;
            fields_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmderr_q <= cmderr_d;
            cmd_q    <= cmd_d;
            fields_q <= fields_d;
        end
    end

    assign go_o       = (state_q == GO);
    assign busy_o     = (state_q != IDLE);
    assign cmderr_o   = cmderr_q;
    assign transfer_o = fields_q.transfer;
    assign write_o    = fields_q.write;
    assign postexec_o = fields_q.postexec;
    assign aarsize_o  = fields_q.aarsize;
    assign regno_o    = fields_q.regno;

endmodule

// File: tb/tb_dm_abstract_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_abstract_ctrl
//
// Two instances (32-bit and 64-bit hart, 16-cycle go timeout) share one
// stimulus stream. For every cycle the stimulus process advances a reference
// model of each instance and queues the expected outputs; a monitor on the
// falling edge pops and compares. Directed sequences cover the command
// scenarios of interest, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_dm_abstract_ctrl;

    localparam int Timeout = 16;

    typedef struct {
        bit        dmactive;
        bit        cmd_valid;
        bit [31:0] cmd;
        bit        autoexec;
        bit        data_access;
        bit [2:0]  clr;
        bit        halted;
        bit        going;
        bit        done;
        bit        exception;
    } stim_t;

    // Abstract view of one instance: is a command outstanding, is the hart
    // still to acknowledge it, and for how many cycles has go been shown.
    typedef struct {
        bit        busy;
        bit        awaiting_go;
        int        go_cycles;
        bit [2:0]  err;
        bit [31:0] stored;
        bit        transfer;
        bit        write;
        bit        postexec;
        int        aarsize;
        int        regno;
    } model_t;

    typedef struct packed {
        logic        go;
        logic        busy;
        logic [2:0]  cmderr;
        logic        transfer;
        logic        write;
        logic        postexec;
        logic [2:0]  aarsize;
        logic [15:0] regno;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmactive, cmd_valid, autoexec, data_access;
    logic [31:0] cmd;
    logic [2:0]  cmderr_clr;
    logic        hart_halted, hart_going, hart_done, hart_exception;

    logic        go32, busy32, tr32, wr32, pe32;
    logic [2:0]  err32, sz32;
    logic [15:0] rg32;
    logic        go64, busy64, tr64, wr64, pe64;
    logic [2:0]  err64, sz64;
    logic [15:0] rg64;

    out_t act32, act64;
    assign act32 = {go32, busy32, err32, tr32, wr32, pe32, sz32, rg32};
    assign act64 = {go64, busy64, err64, tr64, wr64, pe64, sz64, rg64};

    int     n_checks = 0;
    int     n_errors = 0;
    out_t   q32[$];
    out_t   q64[$];
    model_t m32, m64;

    always #5 clk = ~clk;

    dm_abstract_ctrl #(.BusWidth(32), .TimeoutCycles(Timeout)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive),
        .cmd_valid_i(cmd_valid), .cmd_i(cmd), .autoexec_i(autoexec),
        .data_access_i(data_access), .cmderr_clr_i(cmderr_clr),
        .hart_halted_i(hart_halted), .hart_going_i(hart_going),
        .hart_done_i(hart_done), .hart_exception_i(hart_exception),
        .go_o(go32), .busy_o(busy32), .cmderr_o(err32), .transfer_o(tr32),
        .write_o(wr32), .postexec_o(pe32), .aarsize_o(sz32), .regno_o(rg32)
    );

    dm_abstract_ctrl #(.BusWidth(64), .TimeoutCycles(Timeout)) dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive),
        .cmd_valid_i(cmd_valid), .cmd_i(cmd), .autoexec_i(autoexec),
        .data_access_i(data_access), .cmderr_clr_i(cmderr_clr),
        .hart_halted_i(hart_halted), .hart_going_i(hart_going),
        .hart_done_i(hart_done), .hart_exception_i(hart_exception),
        .go_o(go64), .busy_o(busy64), .cmderr_o(err64), .transfer_o(tr64),
        .write_o(wr64), .postexec_o(pe64), .aarsize_o(sz64), .regno_o(rg64)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic model_t advance(model_t m, int bus_width, stim_t s);
        model_t    n;
        bit [31:0] c;
        int        cmdtype, size, regno;
        bit        postinc, postexec, transfer, write, size_legal;
        n = m;
        if (!s.dmactive) begin
            n = '{default: 0};
            return n;
        end
        n.err = m.err & ~s.clr;
        if (!m.busy) begin
            if ((s.cmd_valid || s.autoexec) && n.err == 0) begin
                c = s.cmd_valid ? s.cmd : m.stored;
                if (s.cmd_valid) n.stored = s.cmd;
                cmdtype  = int'(c >> 24);
                size     = int'((c >> 20) & 32'h7);
                postinc  = ((c >> 19) & 32'h1) != 0;
                postexec = ((c >> 18) & 32'h1) != 0;
                transfer = ((c >> 17) & 32'h1) != 0;
                write    = ((c >> 16) & 32'h1) != 0;
                regno    = int'(c & 32'hFFFF);
                size_legal = (size == 2) || (bus_width == 64 && size == 3);
                if (cmdtype != 0 || postinc)           n.err = 3'd2;
                else if (transfer && !size_legal)      n.err = 3'd2;
                else if (transfer && regno > 'h101F)   n.err = 3'd2;
                else if (!s.halted)                    n.err = 3'd4;
                else begin
                    n.transfer = transfer;
                    n.write    = write;
                    n.postexec = postexec;
                    n.aarsize  = size;
                    n.regno    = regno;
                    if (transfer || postexec) begin
                        n.busy        = 1'b1;
                        n.awaiting_go = 1'b1;
                        n.go_cycles   = 0;
                    end
                end
            end
        end else begin
            if ((s.cmd_valid || s.autoexec || s.data_access) && n.err == 0) n.err = 3'd1;
            if (m.awaiting_go) begin
                if (s.going) begin
                    n.awaiting_go = 1'b0;
                end else if (m.go_cycles + 1 == Timeout) begin
                    n.err         = 3'd7;
                    n.busy        = 1'b0;
                    n.awaiting_go = 1'b0;
                end else begin
                    n.go_cycles = m.go_cycles + 1;
                end
            end else if (s.exception) begin
                n.err  = 3'd3;
                n.busy = 1'b0;
            end else if (s.done) begin
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic out_t expect_of(model_t m);
        out_t o;
        o.go       = m.awaiting_go;
        o.busy     = m.busy;
        o.cmderr   = m.err;
        o.transfer = m.transfer;
        o.write    = m.write;
        o.postexec = m.postexec;
        o.aarsize  = 3'(m.aarsize);
        o.regno    = 16'(m.regno);
        return o;
    endfunction

    // ------------------------------------------------------------- stimulus
    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.dmactive = 1'b1;
        s.halted   = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        dmactive       = s.dmactive;
        cmd_valid      = s.cmd_valid;
        cmd            = s.cmd;
        autoexec       = s.autoexec;
        data_access    = s.data_access;
        cmderr_clr     = s.clr;
        hart_halted    = s.halted;
        hart_going     = s.going;
        hart_done      = s.done;
        hart_exception = s.exception;
    endtask

    // One clock: apply inputs, queue the expected post-edge outputs.
    task automatic step(input stim_t s);
        drive(s);
        m32 = advance(m32, 32, s);
        m64 = advance(m64, 64, s);
        q32.push_back(expect_of(m32));
        q64.push_back(expect_of(m64));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] c, input bit halted);
        stim_t s;
        s = nop();
        s.cmd_valid = 1'b1;
        s.cmd       = c;
        s.halted    = halted;
        step(s);
    endtask

    task automatic pulse_going();
        stim_t s;
        s = nop();
        s.going = 1'b1;
        step(s);
    endtask

    task automatic pulse_done();
        stim_t s;
        s = nop();
        s.done = 1'b1;
        step(s);
    endtask

    task automatic clear_err();
        stim_t s;
        s = nop();
        s.clr = 3'b111;
        step(s);
    endtask

    // Asynchronous reset asserted between edges; outputs must be zero before
    // the next edge arrives.
    task automatic async_reset();
        @(negedge clk);
        #1;
        drive(nop());
        rst_ni = 1'b0;
        m32 = '{default: 0};
        m64 = '{default: 0};
        q32.push_back(expect_of(m32));
        q64.push_back(expect_of(m64));
        @(negedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (q32.size() > 0) begin
            out_t e;
            e = q32.pop_front();
            check("dut32 outputs", {4'b0, act32}, {4'b0, e});
        end
        if (q64.size() > 0) begin
            out_t e;
            e = q64.pop_front();
            check("dut64 outputs", {4'b0, act64}, {4'b0, e});
        end
    end

    logic [31:0] cmd_pool [10] = '{
        32'h0023_1008, 32'h0033_1008, 32'h0022_0300, 32'h0100_0000,
        32'h002A_1000, 32'h0004_0000, 32'h0000_0000, 32'h0022_1020,
        32'h0021_1008, 32'h0036_101F
    };

    initial begin
        stim_t s;
        drive(nop());
        async_reset();
        check("reset busy", {31'b0, busy32}, 32'd0);
        check("reset go", {31'b0, go32}, 32'd0);
        check("reset cmderr", {29'b0, err32}, 32'd0);
        check("reset regno", {16'b0, rg32}, 32'd0);

        // Accepted GPR write: go from the first cycle, done ends busy.
        issue(32'h0023_1008, 1'b1);
        @(negedge clk);
        check("gpr regno", {16'b0, rg32}, 32'h1008);
        check("gpr write", {31'b0, wr32}, 32'd1);
        check("gpr go", {31'b0, go32}, 32'd1);
        pulse_going();
        @(negedge clk);
        check("gpr go after going", {31'b0, go32}, 32'd0);
        check("gpr busy in exec", {31'b0, busy32}, 32'd1);
        pulse_done();
        @(negedge clk);
        check("gpr busy after done", {31'b0, busy32}, 32'd0);
        check("gpr cmderr", {29'b0, err32}, 32'd0);

        // Unsupported cmdtype; sticky error blocks the next command.
        issue(32'h0100_0000, 1'b1);
        @(negedge clk);
        check("quick cmderr", {29'b0, err32}, 32'd2);
        issue(32'h0023_1008, 1'b1);
        @(negedge clk);
        check("blocked busy", {31'b0, busy32}, 32'd0);
        clear_err();
        issue(32'h0023_1008, 1'b1);
        @(negedge clk);
        check("after clear busy", {31'b0, busy32}, 32'd1);
        pulse_going();
        pulse_done();

        // 64-bit access: rejected on the 32-bit hart, accepted on the 64-bit.
        issue(32'h0033_1008, 1'b1);
        @(negedge clk);
        check("size3 cmderr32", {29'b0, err32}, 32'd2);
        check("size3 busy64", {31'b0, busy64}, 32'd1);
        pulse_going();
        pulse_done();
        clear_err();

        // Hart running.
        issue(32'h0022_0300, 1'b0);
        @(negedge clk);
        check("not halted cmderr", {29'b0, err32}, 32'd4);
        check("not halted go", {31'b0, go32}, 32'd0);
        clear_err();

        // Access during EXEC flags Busy; command still finishes.
        issue(32'h0023_1008, 1'b1);
        pulse_going();
        s = nop();
        s.data_access = 1'b1;
        step(s);
        @(negedge clk);
        check("exec access cmderr", {29'b0, err32}, 32'd1);
        pulse_done();
        @(negedge clk);
        check("exec access done", {31'b0, busy32}, 32'd0);
        clear_err();

        // Exception and done together.
        issue(32'h0023_1008, 1'b1);
        pulse_going();
        s = nop();
        s.done = 1'b1;
        s.exception = 1'b1;
        step(s);
        @(negedge clk);
        check("exception cmderr", {29'b0, err32}, 32'd3);
        check("exception busy", {31'b0, busy32}, 32'd0);
        clear_err();

        // No going ack: 16 cycles of go, then timeout.
        issue(32'h0023_1008, 1'b1);
        repeat (Timeout - 1) step(nop());
        @(negedge clk);
        check("timeout last go", {31'b0, go32}, 32'd1);
        step(nop());
        @(negedge clk);
        check("timeout cmderr", {29'b0, err32}, 32'd7);
        check("timeout busy", {31'b0, busy32}, 32'd0);
        clear_err();

        // dmactive dropped mid-EXEC.
        issue(32'h0023_1008, 1'b1);
        pulse_going();
        s = nop();
        s.dmactive = 1'b0;
        s.done = 1'b1;
        step(s);
        @(negedge clk);
        check("dmactive busy", {31'b0, busy32}, 32'd0);
        check("dmactive regno", {16'b0, rg32}, 32'd0);
        check("dmactive write", {31'b0, wr32}, 32'd0);
        step(nop());

        // Asynchronous reset mid-command.
        issue(32'h0023_1008, 1'b1);
        pulse_going();
        async_reset();
        check("async busy", {31'b0, busy32}, 32'd0);
        check("async regno", {16'b0, rg32}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            s = nop();
            s.dmactive    = ($urandom % 64) != 0;
            s.cmd_valid   = ($urandom % 6) == 0;
            s.cmd         = (($urandom % 8) == 0) ? $urandom : cmd_pool[$urandom % 10];
            s.autoexec    = ($urandom % 10) == 0;
            s.data_access = ($urandom % 8) == 0;
            s.clr         = (($urandom % 5) == 0) ? 3'($urandom) : 3'd0;
            s.halted      = ($urandom % 8) != 0;
            s.going       = ($urandom % 5) == 0;
            s.done        = ($urandom % 4) == 0;
            s.exception   = ($urandom % 12) == 0;
            step(s);
        end

        drive(nop());
        repeat (2) @(negedge clk);
        check("queue32 drained", q32.size(), 32'd0);
        check("queue64 drained", q64.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
